gemm_tile_issuer: RTL
=====================

Name: gemm_tile_issuer

Overview:
Host-side command initiator for control_unit. Accepts one GEMM job descriptor (full M/K/N plus tile-major base addresses), splits it into W×W tile commands and drives the 64-bit cmd_valid/cmd_data/cmd_ready port of control_unit. It counts done_irq pulses to track outstanding tiles. It orders tiles so that K-accumulation through the D buffer is hazard-free.

Parameters:
ADDR_WIDTH, 10, SRAM address width; must be 10 to match the command packing
SYSTOLIC_ARRAY_WIDTH (W), 16, tile edge; per-tile M/K/N field range is 1..W
DIM_WIDTH, 12, width of the job M/K/N totals
MAX_OUTSTANDING, 4, maximum commands accepted but not yet completed

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
job_valid  in  1  job descriptor valid
job_ready  out  1  issuer can take a job; high only in IDLE
job_m / job_k / job_n  in  DIM_WIDTH each  total matrix dimensions
job_a_base / job_b_base / job_c_base / job_d_base  in  ADDR_WIDTH each  tile-major base addresses
cmd_valid  out  1  command valid to control_unit
cmd_data  out  64  {D[63:54], C[53:44], B[43:34], A[33:24], N[23:16], K[15:8], M[7:0]}
cmd_ready  in  1  control_unit command FIFO ready
done_irq  in  1  one-cycle pulse per completed tile
job_busy  out  1  high from job accept until job_done
job_done  out  1  one-cycle pulse when the last tile completes
outstanding  out  $clog2(MAX_OUTSTANDING+1)  issued-minus-completed count
err_underflow  out  1  sticky; set by done_irq while outstanding==0

Behaviour:
- Reset (rst==0 at posedge): all outputs are 0, job_ready is 0, state is IDLE, all counters are 0. job_ready rises the cycle after reset releases. A reset mid-job abandons the job with no job_done pulse.
- Tile counts: MT=ceil(M/W), KT=ceil(K/W), NT=ceil(N/W).
- Per-tile sizes: m=min(W, M-mt·W), likewise k and n, each encoded in 8 bits.
- Loop order: kt is outermost, then mt, then nt innermost.
- Addresses, computed modulo 2^ADDR_WIDTH (wrap, no error):
  - A = a_base + (mt·KT+kt)·W
  - B = b_base + (kt·NT+nt)·W
  - D = d_base + (mt·NT+nt)·W
  - C = c_base + (mt·NT+nt)·W when kt==0; C = D when kt>0 (accumulate onto the partial result)
- FSM states:
  - IDLE: on job_valid&&job_ready, register the descriptor. Any dimension 0 → DONE. Otherwise → ISSUE.
  - ISSUE: cmd_valid=1 with the current tile, subject to the stall rules below.
  - DRAIN: entered when the next tile begins a new kt>0. Hold cmd_valid=0 until outstanding==0, then → ISSUE.
  - FLUSH: entered after the last tile handshake. Wait for outstanding==0, then → DONE.
  - DONE: job_done=1 for one cycle → IDLE.
- cmd_valid stall rules in ISSUE: cmd_valid is forced to 0 while outstanding==MAX_OUTSTANDING. Once asserted, cmd_valid and cmd_data stay stable until the handshake (cmd_valid&&cmd_ready at posedge).
- Latency and throughput: job accepted at edge T → cmd_valid=1 after edge T. Back-to-back commands at one per cycle; the next tile's data is presented the cycle after the handshake.
- outstanding update: +1 on handshake, −1 on done_irq, unchanged when both happen in the same cycle.
- done_irq with outstanding==0: ignored (counter stays 0) and err_underflow set. err_underflow clears only on reset.
- job_busy = (state != IDLE).

Decomposition:
- Package gemm_cmd_pkg holds:
  - cmd field LSB/MSB localparams
  - typedef struct packed cmd_t {d, c, b, a, n, k, m}
  - typedef enum issuer_state_t
  - function pack_cmd
- The package is shared with control_unit's decoder.
- One sub-module, tile_addr_gen: holds the kt/mt/nt counters, incremental address accumulators (no multipliers), partial-tile sizes, and last/k-boundary flags. Advances on a single "step" input.

Test Plan:
1. Single tile. Job M=K=N=16, bases A=0, B=100, C=200, D=300.
   → One cmd = {300,200,100,0,16,16,16}. After done_irq, job_done pulses the next cycle, then job_busy=0.
2. Partial tile. M=20, K=16, N=8, same bases.
   → cmd0 {D300, C200, B100, A0, N8, K16, M16}, then cmd1 {D316, C216, B100, A16, N8, K16, M4}.
3. K accumulation. M=16, K=32, N=16.
   → cmd0 {300,200,100,0,16,16,16}. cmd_valid stays low until done_irq. Then cmd1 {300,300,116,16,16,16,16}.
4. Backpressure. Hold cmd_ready=0 for 5 cycles → cmd_valid held, cmd_data unchanged.
   With MAX_OUTSTANDING=2 and no done_irq, the 3rd tile is withheld until one done_irq arrives.
5. Counter edge cases. Handshake and done_irq in the same cycle → outstanding unchanged.
   done_irq while idle → err_underflow=1, outstanding stays 0. A zero-size job → job_done with no cmd.
6. Reset mid-job. Drop rst during ISSUE of a 4-tile job → next edge: cmd_valid=0, outstanding=0, no job_done. A new job is accepted afterwards.

Source files
------------

// File: rtl/gemm_cmd_pkg.sv
// Command word layout, issuer FSM states and the packing helper shared by
// the tile issuer and control_unit's command decoder.
package gemm_cmd_pkg;

  localparam int CMD_W      = 64;
  localparam int CMD_SIZE_W = 8;
  localparam int CMD_ADDR_W = 10;

  localparam int CMD_M_LSB = 0;
  localparam int CMD_M_MSB = 7;
  localparam int CMD_K_LSB = 8;
  localparam int CMD_K_MSB = 15;
  localparam int CMD_N_LSB = 16;
  localparam int CMD_N_MSB = 23;
  localparam int CMD_A_LSB = 24;
  localparam int CMD_A_MSB = 33;
  localparam int CMD_B_LSB = 34;
  localparam int CMD_B_MSB = 43;
  localparam int CMD_C_LSB = 44;
  localparam int CMD_C_MSB = 53;
  localparam int CMD_D_LSB = 54;
  localparam int CMD_D_MSB = 63;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] d;
    logic [CMD_ADDR_W-1:0] c;
    logic [CMD_ADDR_W-1:0] b;
    logic [CMD_ADDR_W-1:0] a;
    logic [CMD_SIZE_W-1:0] n;
    logic [CMD_SIZE_W-1:0] k;
    logic [CMD_SIZE_W-1:0] m;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } issuer_state_t;

  function automatic logic [CMD_W-1:0] pack_cmd(input cmd_t c);
    logic [CMD_W-1:0] r;
    r = '0;
    r[CMD_D_MSB:CMD_D_LSB] = c.d;
    r[CMD_C_MSB:CMD_C_LSB] = c.c;
    r[CMD_B_MSB:CMD_B_LSB] = c.b;
    r[CMD_A_MSB:CMD_A_LSB] = c.a;
    r[CMD_N_MSB:CMD_N_LSB] = c.n;
    r[CMD_K_MSB:CMD_K_LSB] = c.k;
    r[CMD_M_MSB:CMD_M_LSB] = c.m;
    return r;
  endfunction

endpackage

// File: rtl/gemm_tile_issuer_tile_addr_gen.sv
// Tile walker: kt (outer) / mt / nt (inner) counters with incremental
// address accumulators, so no multipliers are needed. Advances on step.
module tile_addr_gen
  import gemm_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int W          = 16,
  parameter int DIM_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DIM_WIDTH-1:0]  job_m,
  input  logic [DIM_WIDTH-1:0]  job_k,
  input  logic [DIM_WIDTH-1:0]  job_n,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  input  logic [ADDR_WIDTH-1:0] d_base,
  output logic [ADDR_WIDTH-1:0] tile_a,
  output logic [ADDR_WIDTH-1:0] tile_b,
  output logic [ADDR_WIDTH-1:0] tile_c,
  output logic [ADDR_WIDTH-1:0] tile_d,
  output logic [CMD_SIZE_W-1:0] tile_m,
  output logic [CMD_SIZE_W-1:0] tile_k,
  output logic [CMD_SIZE_W-1:0] tile_n,
  output logic                  last_tile,
  output logic                  k_boundary
);

  localparam int LOG2W = $clog2(W);
  localparam logic [ADDR_WIDTH-1:0] W_A   = ADDR_WIDTH'(W);
  localparam logic [DIM_WIDTH-1:0]  W_D   = DIM_WIDTH'(W);
  localparam logic [DIM_WIDTH-1:0]  ONE_D = DIM_WIDTH'(1);

  logic [DIM_WIDTH-1:0]  kt, mt, nt, kt_last, mt_last, nt_last;
  logic [DIM_WIDTH-1:0]  m_tot, n_tot, rem_m, rem_k, rem_n;
  logic [ADDR_WIDTH-1:0] a_stride, b_stride, c_start, d_start;
  logic [ADDR_WIDTH-1:0] a_kt, b_kt, a_cur, b_cur, c_cur, d_cur;
  logic                  nt_end, mt_end, kt_end;

  // ceil(dim/W) - 1, i.e. the index of the last tile along a dimension
  function automatic logic [DIM_WIDTH-1:0] tiles_m1(input logic [DIM_WIDTH-1:0] dim);
    logic [DIM_WIDTH:0] t;
    t = ({1'b0, dim} + (DIM_WIDTH+1)'(W - 1)) >> LOG2W;
    return DIM_WIDTH'(t - (DIM_WIDTH+1)'(1));
  endfunction

  // tile count times W, reduced modulo the address space
  function automatic logic [ADDR_WIDTH-1:0] span(input logic [DIM_WIDTH-1:0] dim);
    logic [DIM_WIDTH-1:0] cnt;
    cnt = tiles_m1(dim) + ONE_D;
    return ADDR_WIDTH'({cnt, {LOG2W{1'b0}}});
  endfunction

  function automatic logic [CMD_SIZE_W-1:0] size_of(input logic [DIM_WIDTH-1:0] rem);
    return (rem >= W_D) ? CMD_SIZE_W'(W) : rem[CMD_SIZE_W-1:0];
  endfunction

  assign nt_end = (nt == nt_last);
  assign mt_end = (mt == mt_last);
  assign kt_end = (kt == kt_last);

  // Loop counters and their limits
  always_ff @(posedge clk) begin
    if (!rst) begin
      kt      <= '0;
      mt      <= '0;
      nt      <= '0;
      kt_last <= '0;
      mt_last <= '0;
      nt_last <= '0;
    end else if (load) begin
      kt      <= '0;
      mt      <= '0;
      nt      <= '0;
      kt_last <= tiles_m1(job_k);
      mt_last <= tiles_m1(job_m);
      nt_last <= tiles_m1(job_n);
    end else if (step) begin
      if (!nt_end) begin
        nt <= nt + ONE_D;
      end else begin
        nt <= '0;
        if (!mt_end) begin
          mt <= mt + ONE_D;
        end else begin
          mt <= '0;
          kt <= kt + ONE_D;
        end
      end
    end
  end

  // Remaining-extent trackers and address accumulators
  always_ff @(posedge clk) begin
    if (load) begin
      m_tot    <= job_m;
      n_tot    <= job_n;
      rem_m    <= job_m;
      rem_k    <= job_k;
      rem_n    <= job_n;
      a_stride <= span(job_k);
      b_stride <= span(job_n);
      a_kt     <= a_base;
      a_cur    <= a_base;
      b_kt     <= b_base;
      b_cur    <= b_base;
      c_start  <= c_base;
      d_start  <= d_base;
      c_cur    <= c_base;
      d_cur    <= d_base;
    end else if (step) begin
      if (!nt_end) begin
        rem_n <= rem_n - W_D;
        b_cur <= b_cur + W_A;
      end else begin
        rem_n <= n_tot;
        if (!mt_end) begin
          rem_m <= rem_m - W_D;
          a_cur <= a_cur + a_stride;
          b_cur <= b_kt;
        end else begin
          rem_m <= m_tot;
          rem_k <= rem_k - W_D;
          a_kt  <= a_kt + W_A;
          a_cur <= a_kt + W_A;
          b_kt  <= b_kt + b_stride;
          b_cur <= b_kt + b_stride;
        end
      end
      // C/D walk the output tiles linearly and restart with every kt pass
      if (nt_end && mt_end) begin
        c_cur <= c_start;
        d_cur <= d_start;
      end else begin
        c_cur <= c_cur + W_A;
        d_cur <= d_cur + W_A;
      end
    end
  end

  assign tile_a     = a_cur;
  assign tile_b     = b_cur;
  assign tile_d     = d_cur;
  assign tile_c     = (kt == '0) ? c_cur : d_cur;
  assign tile_m     = size_of(rem_m);
  assign tile_k     = size_of(rem_k);
  assign tile_n     = size_of(rem_n);
  assign last_tile  = nt_end && mt_end && kt_end;
  assign k_boundary = nt_end && mt_end && !kt_end;

endmodule

// File: rtl/gemm_tile_issuer.sv
// Splits one GEMM job into WxW tile commands for control_unit, tracks
// outstanding tiles via done_irq and drains between K passes so the
// D-buffer accumulation never reads a partial result still in flight.
module gemm_tile_issuer
  import gemm_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH           = 10,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DIM_WIDTH            = 12,
  parameter int MAX_OUTSTANDING      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 job_valid,
  output logic                                 job_ready,
  input  logic [DIM_WIDTH-1:0]                 job_m,
  input  logic [DIM_WIDTH-1:0]                 job_k,
  input  logic [DIM_WIDTH-1:0]                 job_n,
  input  logic [ADDR_WIDTH-1:0]                job_a_base,
  input  logic [ADDR_WIDTH-1:0]                job_b_base,
  input  logic [ADDR_WIDTH-1:0]                job_c_base,
  input  logic [ADDR_WIDTH-1:0]                job_d_base,
  output logic                                 cmd_valid,
  output logic [63:0]                          cmd_data,
  input  logic                                 cmd_ready,
  input  logic                                 done_irq,
  output logic                                 job_busy,
  output logic                                 job_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_underflow
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  issuer_state_t             state;
  logic                      accept, zero_job, hs, underflow, dec;
  logic [OUT_W-1:0]          out_nxt;
  logic [ADDR_WIDTH-1:0]     tile_a, tile_b, tile_c, tile_d;
  logic [CMD_SIZE_W-1:0]     tile_m, tile_k, tile_n;
  logic                      last_tile, k_boundary;
  cmd_t                      cur_cmd;

  assign accept    = job_valid && job_ready;
  assign zero_job  = (job_m == '0) || (job_k == '0) || (job_n == '0);
  assign hs        = cmd_valid && cmd_ready;
  assign underflow = done_irq && (outstanding == '0);
  assign dec       = done_irq && !underflow;
  assign job_busy  = (state != ST_IDLE);

  tile_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .W          (SYSTOLIC_ARRAY_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (hs),
    .job_m      (job_m),
    .job_k      (job_k),
    .job_n      (job_n),
    .a_base     (job_a_base),
    .b_base     (job_b_base),
    .c_base     (job_c_base),
    .d_base     (job_d_base),
    .tile_a     (tile_a),
    .tile_b     (tile_b),
    .tile_c     (tile_c),
    .tile_d     (tile_d),
    .tile_m     (tile_m),
    .tile_k     (tile_k),
    .tile_n     (tile_n),
    .last_tile  (last_tile),
    .k_boundary (k_boundary)
  );

  always_comb begin
    cur_cmd = '{d: tile_d, c: tile_c, b: tile_b, a: tile_a,
                n: tile_n, k: tile_k, m: tile_m};
  end

  // Data is zeroed whenever no command is offered
  assign cmd_data = cmd_valid ? pack_cmd(cur_cmd) : '0;

  // Next outstanding count: a handshake and a completion in the same cycle cancel
  always_comb begin
    out_nxt = outstanding;
    if (hs && !dec) begin
      out_nxt = outstanding + OUT_ONE;
    end else if (dec && !hs) begin
      out_nxt = outstanding - OUT_ONE;
    end
  end

  // Issuer FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cmd_valid     <= 1'b0;
      job_ready     <= 1'b0;
      job_done      <= 1'b0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      job_done    <= 1'b0;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          job_ready <= 1'b1;
          if (accept) begin
            job_ready <= 1'b0;
            if (zero_job) begin
              state    <= ST_DONE;
              job_done <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              cmd_valid <= (out_nxt != OUT_MAX);
            end
          end
        end
        ST_ISSUE: begin
          if (hs && last_tile) begin
            state     <= ST_FLUSH;
            cmd_valid <= 1'b0;
          end else if (hs && k_boundary) begin
            state     <= ST_DRAIN;
            cmd_valid <= 1'b0;
          end else begin
            cmd_valid <= (out_nxt != OUT_MAX);
          end
        end
        ST_DRAIN: begin
          if (out_nxt == '0) begin
            state     <= ST_ISSUE;
            cmd_valid <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (out_nxt == '0) begin
            state    <= ST_DONE;
            job_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          job_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
